// File: rtl/goertzel_bin_scanner.sv
// Sweeps goertzel bin coefficients frame by frame, records per-bin power and reports the strongest bin per sweep.
// Optional BIN_SCAN_THRESH_EN gates peak reporting on a minimum power of THRESHOLD.
module goertzel_bin_scanner #(
    parameter int                 NUM_BINS  = 8,
    parameter int                 BIN_W     = 3,
    parameter logic signed [63:0] THRESHOLD = 64'sd4096
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic signed [63:0]       power,
    input  logic                     advance,
    output logic signed [31:0]       bin_coeff,
    output logic [BIN_W-1:0]         bin_index,
    input  logic                     coeff_we,
    input  logic [BIN_W-1:0]         coeff_addr,
    input  logic signed [31:0]       coeff_wdata,
    input  logic [BIN_W-1:0]         rd_addr,
    output logic signed [63:0]       rd_data,
    output logic [BIN_W-1:0]         peak_bin,
    output logic signed [63:0]       peak_power,
    output logic                     peak_valid,
    output logic [15:0]              sweep_count
);

    if (NUM_BINS < 2 || NUM_BINS > 64 || THRESHOLD < 0) begin : g_param_check
        $error("goertzel_bin_scanner: parameter out of range");
    end

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    typedef enum logic [1:0] {IDLE, SYNC, SCAN} state_t;
    state_t state, state_nxt;

    logic signed [31:0] coeff_mem [NUM_BINS];
    logic signed [63:0] power_mem [NUM_BINS];

    logic signed [63:0] run_max, fin_max, cmp_val;
    logic [BIN_W-1:0]   run_bin, fin_bin, next_idx, load_idx;
    logic signed [31:0] load_coeff;
    logic               capture, last, go_idle, peak_fire;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = SYNC;
            SYNC:    if (!enable) state_nxt = IDLE;
                     else if (advance) state_nxt = SCAN;
            SCAN:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign capture  = (state == SCAN) && enable && advance;
    assign last     = (bin_index == LAST_BIN);
    assign go_idle  = (state_nxt == IDLE);
    assign next_idx = last ? '0 : bin_index + 1'b1;
    assign load_idx = capture ? next_idx : '0;
    // Write-first: a coefficient written on the loading edge is the one handed to the core.
    assign load_coeff = (coeff_we && coeff_addr == load_idx) ? coeff_wdata : coeff_mem[load_idx];

    // Negative power only competes as zero; bin 0 restarts the running max every sweep.
    assign cmp_val = power[63] ? 64'sd0 : power;

    always_comb begin
        fin_max = run_max;
        fin_bin = run_bin;
        if (bin_index == '0 || cmp_val > run_max) begin
            fin_max = cmp_val;
            fin_bin = bin_index;
        end
    end

`ifdef BIN_SCAN_THRESH_EN
    assign peak_fire = capture && last && (fin_max >= THRESHOLD);
`else
    assign peak_fire = capture && last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                coeff_mem[i] <= '0;
                power_mem[i] <= '0;
            end
            bin_index   <= '0;
            bin_coeff   <= '0;
            rd_data     <= '0;
            run_max     <= '0;
            run_bin     <= '0;
            peak_bin    <= '0;
            peak_power  <= '0;
            peak_valid  <= 1'b0;
            sweep_count <= '0;
        end else begin
            peak_valid <= 1'b0;
            rd_data    <= power_mem[rd_addr];
            if (coeff_we) coeff_mem[coeff_addr] <= coeff_wdata;

            if (capture) begin
                power_mem[bin_index] <= power;
                bin_index            <= next_idx;
                bin_coeff            <= load_coeff;
                if (last) begin
                    run_max     <= '0;
                    run_bin     <= '0;
                    sweep_count <= sweep_count + 16'd1;
                    if (peak_fire) begin
                        peak_bin   <= fin_bin;
                        peak_power <= fin_max;
                        peak_valid <= 1'b1;
                    end
                end else begin
                    run_max <= fin_max;
                    run_bin <= fin_bin;
                end
            end else if (go_idle) begin
                // Partial sweeps are dropped; IDLE keeps bin 0 staged for the next start.
                bin_index <= '0;
                bin_coeff <= load_coeff;
                run_max   <= '0;
                run_bin   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_goertzel_bin_scanner.sv
// Directed bench for goertzel_bin_scanner; peak reports are checked by a queue-based scoreboard.
module tb_goertzel_bin_scanner;

    logic               clk = 1'b0;
    logic               reset, enable, advance, coeff_we;
    logic signed [63:0] power;
    logic signed [31:0] bin_coeff, coeff_wdata;
    logic [2:0]         bin_index, coeff_addr, rd_addr, peak_bin;
    logic signed [63:0] rd_data, peak_power;
    logic               peak_valid;
    logic [15:0]        sweep_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  bin;
        logic [63:0] pow;
        bit          chk_pow;
    } exp_t;
    exp_t exp_q[$];

    goertzel_bin_scanner dut (
        .clk(clk), .reset(reset), .enable(enable), .power(power), .advance(advance),
        .bin_coeff(bin_coeff), .bin_index(bin_index), .coeff_we(coeff_we),
        .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata), .rd_addr(rd_addr),
        .rd_data(rd_data), .peak_bin(peak_bin), .peak_power(peak_power),
        .peak_valid(peak_valid), .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic signed [63:0] p);
        advance = 1'b1;
        power   = p;
        tick();
        advance = 1'b0;
        power   = '0;
    endtask

    task automatic expect_peak(input logic [2:0] b, input logic [63:0] p, input bit cp);
        exp_t e;
        e.bin = b; e.pow = p; e.chk_pow = cp;
`ifdef BIN_SCAN_THRESH_EN
        if ($signed(p) >= 64'sd4096) exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
    endtask

    always @(negedge clk) begin
        if (!reset && peak_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_peak_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("peak_bin", 64'(peak_bin), 64'(e.bin));
                if (e.chk_pow) chk("peak_power", peak_power, e.pow);
            end
        end
    end

    initial begin
        int p2[8];
        int p4[8];
        p2 = '{-5, 7, 7, 0, 0, 0, 0, 0};
        p4 = '{5, 9, 3, 9, 2, 1, 0, 4};
        reset = 1'b1; enable = 1'b0; advance = 1'b0; power = '0;
        coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_bin_index", 64'(bin_index), 64'd0);
        chk("rst_bin_coeff", 64'(bin_coeff), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_peak_bin", 64'(peak_bin), 64'd0);
        chk("rst_peak_power", peak_power, 64'd0);
        chk("rst_peak_valid", 64'(peak_valid), 64'd0);
        chk("rst_sweep_count", 64'(sweep_count), 64'd0);

        for (int k = 0; k < 8; k++) begin
            coeff_we    = 1'b1;
            coeff_addr  = 3'(k);
            coeff_wdata = (k == 1) ? 32'sh0012_3456 : 32'sh100 + k;
            tick();
        end
        coeff_we = 1'b0;
        chk("idle_coeff0", 64'(bin_coeff), 64'h100);

        // SYNC: first advance discarded
        enable = 1'b1;
        tick();
        adv(64'sd999);
        chk("sync_bin_index", 64'(bin_index), 64'd0);
        chk("sync_sweep_count", 64'(sweep_count), 64'd0);

        // Sweep 1: ramp
        expect_peak(3'd7, 64'd80, 1'b1);
        for (int k = 0; k < 8; k++) begin
            adv(64'(10 * (k + 1)));
            if (k == 0) begin
                chk("handoff_bin_index", 64'(bin_index), 64'd1);
                chk("handoff_bin_coeff", 64'(bin_coeff), 64'h0012_3456);
            end
        end
        chk("s1_sweep_count", 64'(sweep_count), 64'd1);
        chk("s1_wrap_index", 64'(bin_index), 64'd0);
        chk("s1_wrap_coeff", 64'(bin_coeff), 64'h100);
        for (int k = 0; k < 8; k++) begin
            rd_addr = 3'(k);
            tick();
            chk("s1_power_mem", rd_data, 64'(10 * (k + 1)));
        end

        // Sweep 2: ties and negatives, plus read-during-capture
        expect_peak(3'd1, 64'd7, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) rd_addr = 3'd3;
            adv(64'(p2[k]));
            if (k == 3) chk("rd_old_value", rd_data, 64'd40);
            if (k == 4) chk("rd_new_value", rd_data, 64'd0);
        end
        chk("s2_sweep_count", 64'(sweep_count), 64'd2);

        // Sweep 3: all negative
        expect_peak(3'd0, 64'd0, 1'b0);
        for (int k = 0; k < 8; k++) adv(-64'(k + 1));
        chk("s3_sweep_count", 64'(sweep_count), 64'd3);
        rd_addr = 3'd2; tick(); tick();
        chk("s3_raw_neg2", rd_data, -64'sd3);
        rd_addr = 3'd7; tick();
        chk("s3_raw_neg7", rd_data, -64'sd8);

        // Partial sweep, then enable drops in the same cycle as an advance
        for (int k = 0; k < 4; k++) adv(64'(100 + k));
        enable = 1'b0; advance = 1'b1; power = 64'sd12345;
        tick();
        advance = 1'b0; power = '0;
        chk("drop_bin_index", 64'(bin_index), 64'd0);
        chk("drop_bin_coeff", 64'(bin_coeff), 64'h100);
        tick(); tick(); tick();
        chk("drop_sweep_count", 64'(sweep_count), 64'd3);
        rd_addr = 3'd4; tick();
        chk("drop_no_capture", rd_data, -64'sd5);
        rd_addr = 3'd0; tick();
        chk("drop_kept_entry", rd_data, 64'd100);

        // Re-enable: SYNC again discards one advance
        enable = 1'b1;
        tick();
        adv(64'sd7777);
        chk("resync_bin_index", 64'(bin_index), 64'd0);
        expect_peak(3'd1, 64'd9, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                coeff_we = 1'b1; coeff_addr = 3'd2; coeff_wdata = 32'sh5EAD_0002;
                tick();
                coeff_we = 1'b0;
                chk("active_coeff_hold", 64'(bin_coeff), 64'h102);
                coeff_we = 1'b1; coeff_addr = 3'd3; coeff_wdata = 32'sh7EEF_0003;
            end
            adv(64'(p4[k]));
            coeff_we = 1'b0;
            if (k == 2) chk("write_first_load", 64'(bin_coeff), 64'h7EEF_0003);
        end
        chk("s4_sweep_count", 64'(sweep_count), 64'd4);

`ifdef BIN_SCAN_THRESH_EN
        for (int k = 0; k < 8; k++) adv((k == 5) ? 64'sd4095 : 64'sd0);
        chk("th_below_count", 64'(sweep_count), 64'd5);
        expect_peak(3'd6, 64'd4096, 1'b1);
        for (int k = 0; k < 8; k++) adv((k == 6) ? 64'sd4096 : 64'sd0);
        chk("th_at_count", 64'(sweep_count), 64'd6);
`endif

        tick(); tick(); tick();
        chk("pending_peaks", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
